imem_loader: RTL

Write-side loader for the CPU's 64-word instruction memory. It accepts a byte stream over a valid/ready handshake and assembles little-endian 32-bit words. Each completed word is written to consecutive word addresses from 0 through a single-cycle write port. While a load is in progress, the CPU core is held off via cpu_hold.

---
 rtl/imem_loader.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/imem_loader.sv
// Instruction-memory loader: assembles a little-endian byte stream into 32-bit
// words, writes them to consecutive addresses from 0 and holds the CPU until done.
module imem_loader #(
  parameter int DEPTH = 64,
  parameter int CNT_W = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] word_count,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  output logic             in_ready,
  output logic             mem_we,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [31:0]      checksum,
  output logic             cpu_hold
);

  localparam int IDX_W = $clog2(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_RECV, S_WRITE, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [IDX_W-1:0] index_q, index_d;
  logic [1:0]       lane_q, lane_d;
  logic [23:0]      word_q, word_d;
  logic             in_ready_q, in_ready_d;
  logic             mem_we_q, mem_we_d;
  logic [31:0]      mem_addr_q, mem_addr_d;
  logic [31:0]      mem_wdata_q, mem_wdata_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             error_q, error_d;
  logic [31:0]      checksum_q, checksum_d;
  logic             cpu_hold_q, cpu_hold_d;

  logic count_ok;
  logic xfer;

  assign count_ok = (word_count != '0) && (word_count <= CNT_W'(DEPTH));
  assign xfer     = in_valid && in_ready_q;

  always_comb begin
    // NOTE: every _d starts as its _q so no branch of the case can infer a latch.
    state_d     = state_q;
    count_d     = count_q;
    index_d     = index_q;
    lane_d      = lane_q;
    word_d      = word_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    error_d     = error_q;
    checksum_d  = checksum_q;
    cpu_hold_d  = cpu_hold_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (count_ok) begin
            count_d    = word_count;
            index_d    = '0;
            lane_d     = '0;
            checksum_d = '0;
            error_d    = 1'b0;
            cpu_hold_d = 1'b1;
            state_d    = S_RECV;
          end else begin
            error_d = 1'b1;
          end
        end
      end
      S_RECV: begin
        if (xfer) begin
          lane_d = lane_q + 2'd1;
          case (lane_q)
            2'd0: word_d[7:0]   = in_data;
            2'd1: word_d[15:8]  = in_data;
            2'd2: word_d[23:16] = in_data;
            default: begin
              mem_addr_d  = 32'({index_q, 2'b00});
              mem_wdata_d = {in_data, word_q};
              state_d     = S_WRITE;
            end
          endcase
        end
      end
      S_WRITE: begin
        checksum_d = checksum_q + mem_wdata_q;
        // The loop ends before index can step past the latched count, so it never wraps.
        if (CNT_W'(index_q) + CNT_W'(1) == count_q) begin
          state_d = S_DONE;
        end else begin
          index_d = index_q + IDX_W'(1);
          lane_d  = '0;
          state_d = S_RECV;
        end
      end
      S_DONE: begin
        cpu_hold_d = 1'b0;
        state_d    = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Status outputs are registered views of the state being entered.
    in_ready_d = (state_d == S_RECV);
    mem_we_d   = (state_d == S_WRITE);
    busy_d     = (state_d == S_RECV) || (state_d == S_WRITE);
    done_d     = (state_d == S_DONE);
  end

  // NOTE: non-blocking assignments so every flop updates from the same pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      count_q     <= '0;
      index_q     <= '0;
      lane_q      <= '0;
      word_q      <= '0;
      in_ready_q  <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      checksum_q  <= '0;
      cpu_hold_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      index_q     <= index_d;
      lane_q      <= lane_d;
      word_q      <= word_d;
      in_ready_q  <= in_ready_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      error_q     <= error_d;
      checksum_q  <= checksum_d;
      cpu_hold_q  <= cpu_hold_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign error     = error_q;
  assign checksum  = checksum_q;
  assign cpu_hold  = cpu_hold_q;

endmodule
